// File: rtl/pll_dyn_ctrl.sv
// pll_dyn_ctrl: sequencer for a GW5A PLL in dynamic mode.
// Runs the power-up reset/lock sequence and qualifies lock. Counts lock-loss
// events. Executes runtime requests: divider change, phase step, full re-lock.
// Clocked from the free-running board oscillator, never from a PLL output.
//
// Optional feature: define PLL_AUTO_RELOCK_EN to re-run the reset/lock
// sequence automatically after a lock loss once the FSM is back in IDLE.
//
// Ports:
//   clk, rst_n            free-running reference clock, async active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_op/req_ch/req_arg 00=set ODIV, 01=phase step {dir,steps}, 10=re-lock
//   done, err             one-cycle completion / error pulses
//   pll_lock              raw PLL LOCK (asynchronous)
//   pll_reset, pll_odsel, pll_pssel, pll_psdir, pll_pspulse, pll_enclk  PLL pins
//   locked, lock_loss_cnt qualified lock, saturating lock-loss count
module pll_dyn_ctrl #(
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned ODIV_INIT     = 8,
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE   = 32,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned PS_GAP        = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [2:0]          req_ch,
    input  logic [6:0]          req_arg,
    output logic                done,
    output logic                err,
    input  logic                pll_lock,
    output logic                pll_reset,
    output logic [7*NUM_CH-1:0] pll_odsel,
    output logic [2:0]          pll_pssel,
    output logic                pll_psdir,
    output logic                pll_pspulse,
    output logic [NUM_CH-1:0]   pll_enclk,
    output logic                locked,
    output logic [7:0]          lock_loss_cnt
);

    localparam int unsigned ODW     = 7;
    localparam int unsigned MAX_A   = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
    localparam int unsigned MAX_B   = (SETTLE_CYCLES > PS_GAP) ? SETTLE_CYCLES : PS_GAP;
    localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > MAX_C) ? LOCK_TIMEOUT : MAX_C;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] OP_ODIV   = 2'b00;
    localparam logic [1:0] OP_PHASE  = 2'b01;
    localparam logic [1:0] OP_RELOCK = 2'b10;
    localparam logic [1:0] OP_BAD    = 2'b11;

`ifdef PLL_AUTO_RELOCK_EN
    localparam bit AUTO_RELOCK = 1'b1;
`else
    localparam bit AUTO_RELOCK = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_RST_ASSERT, S_WAIT_LOCK, S_STABLE, S_IDLE, S_GATE,
        S_WRITE, S_SETTLE, S_PS_PULSE, S_PS_GAP
    } state_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [2:0]             ch_q, ch_nxt;
    logic [ODW-1:0]         arg_q, arg_nxt;
    logic [5:0]             steps_q, steps_nxt;
    logic                   relock_pend, relock_nxt;
    logic                   lock_meta, lock_s;
    logic                   accept, illegal;
    logic                   ready_nxt, done_nxt, err_nxt, reset_nxt, pulse_nxt;
    logic                   psdir_nxt, locked_nxt;
    logic [2:0]             pssel_nxt;
    logic [ODW*NUM_CH-1:0]  odsel_nxt;
    logic [NUM_CH-1:0]      enclk_nxt;
    logic [7:0]             loss_cnt_nxt;

    // Two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RST_ASSERT;
        else        state <= state_nxt;
    end

    // Next state and next registered outputs
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt + CNT_W'(1);
        ch_nxt       = ch_q;
        arg_nxt      = arg_q;
        steps_nxt    = steps_q;
        relock_nxt   = relock_pend;
        odsel_nxt    = pll_odsel;
        enclk_nxt    = pll_enclk;
        pssel_nxt    = pll_pssel;
        psdir_nxt    = pll_psdir;
        locked_nxt   = locked;
        loss_cnt_nxt = lock_loss_cnt;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        accept       = req_valid && req_ready;
        illegal      = (32'(req_ch) >= NUM_CH) || (req_op == OP_BAD) ||
                       ((req_op == OP_ODIV) && (req_arg == 7'd0));

        // Lock loss is observed in every state; the FSM reacts only from IDLE
        if (locked && !lock_s) begin
            locked_nxt = 1'b0;
            if (lock_loss_cnt != 8'hFF) loss_cnt_nxt = lock_loss_cnt + 8'd1;
        end

        case (state)
            S_RST_ASSERT: begin
                if (cnt == CNT_W'(RST_CYCLES - 1)) state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = S_STABLE;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_RST_ASSERT;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_nxt = S_WAIT_LOCK;
                end else if (cnt >= CNT_W'(LOCK_STABLE - 1)) begin
                    state_nxt  = S_IDLE;
                    locked_nxt = 1'b1;
                    enclk_nxt  = '1;
                    done_nxt   = relock_pend;
                    relock_nxt = 1'b0;
                end
            end
            S_IDLE: begin
                if (AUTO_RELOCK && !locked) begin
                    state_nxt = S_RST_ASSERT;
                    enclk_nxt = '0;
                end else if (accept) begin
                    ch_nxt  = req_ch;
                    arg_nxt = req_arg;
                    if (illegal) begin
                        done_nxt = 1'b1;
                        err_nxt  = 1'b1;
                    end else begin
                        case (req_op)
                            OP_ODIV: begin
                                state_nxt = S_GATE;
                                for (int i = 0; i < NUM_CH; i++)
                                    if (3'(i) == req_ch) enclk_nxt[i] = 1'b0;
                            end
                            OP_PHASE: begin
                                pssel_nxt = req_ch;
                                psdir_nxt = req_arg[6];
                                steps_nxt = req_arg[5:0];
                                if (req_arg[5:0] == 6'd0) done_nxt  = 1'b1;
                                else                      state_nxt = S_PS_PULSE;
                            end
                            OP_RELOCK: begin
                                state_nxt  = S_RST_ASSERT;
                                enclk_nxt  = '0;
                                locked_nxt = 1'b0;
                                relock_nxt = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            S_GATE:  state_nxt = S_WRITE;
            S_WRITE: begin
                for (int i = 0; i < NUM_CH; i++)
                    if (3'(i) == ch_q) odsel_nxt[i*ODW +: ODW] = arg_q;
                state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    for (int i = 0; i < NUM_CH; i++)
                        if (3'(i) == ch_q) enclk_nxt[i] = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_PS_PULSE: begin
                steps_nxt = steps_q - 6'd1;
                state_nxt = S_PS_GAP;
            end
            S_PS_GAP: begin
                if (cnt == CNT_W'(PS_GAP - 1)) begin
                    if (steps_q != 6'd0) begin
                        state_nxt = S_PS_PULSE;
                    end else begin
                        done_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_RST_ASSERT;
        endcase

        // Entering STABLE counts the WAIT_LOCK cycle that already saw lock
        if (state_nxt != state) cnt_nxt = (state_nxt == S_STABLE) ? CNT_W'(1) : '0;

        reset_nxt = (state_nxt == S_RST_ASSERT);
        pulse_nxt = (state_nxt == S_PS_PULSE);
        ready_nxt = (state == S_IDLE) && (state_nxt == S_IDLE) && !accept &&
                    (!AUTO_RELOCK || locked_nxt);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            ch_q          <= '0;
            arg_q         <= '0;
            steps_q       <= '0;
            relock_pend   <= 1'b0;
            req_ready     <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            pll_reset     <= 1'b1;
            pll_odsel     <= {NUM_CH{ODW'(ODIV_INIT)}};
            pll_pssel     <= '0;
            pll_psdir     <= 1'b0;
            pll_pspulse   <= 1'b0;
            pll_enclk     <= '0;
            locked        <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            cnt           <= cnt_nxt;
            ch_q          <= ch_nxt;
            arg_q         <= arg_nxt;
            steps_q       <= steps_nxt;
            relock_pend   <= relock_nxt;
            req_ready     <= ready_nxt;
            done          <= done_nxt;
            err           <= err_nxt;
            pll_reset     <= reset_nxt;
            pll_odsel     <= odsel_nxt;
            pll_pssel     <= pssel_nxt;
            pll_psdir     <= psdir_nxt;
            pll_pspulse   <= pulse_nxt;
            pll_enclk     <= enclk_nxt;
            locked        <= locked_nxt;
            lock_loss_cnt <= loss_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Bench for pll_dyn_ctrl (default parameters). Requests push their expected
// completion into a scoreboard; a monitor pops and compares on every done.
// Build with PLL_AUTO_RELOCK_EN defined to exercise the auto re-lock variant.
module tb_pll_dyn_ctrl;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op    = '0;
    logic [2:0]  req_ch    = '0;
    logic [6:0]  req_arg   = '0;
    logic        pll_lock  = 1'b0;
    logic        req_ready, done, err, pll_reset, pll_psdir, pll_pspulse, locked;
    logic [13:0] pll_odsel;
    logic [2:0]  pll_pssel;
    logic [1:0]  pll_enclk;
    logic [7:0]  lock_loss_cnt;

    typedef struct {
        string       name;
        int unsigned acc;
        int unsigned lat;
        logic        err;
        logic [13:0] odsel;
        logic [1:0]  enclk;
        logic        locked;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;
    logic [13:0] exp_odsel = {7'd8, 7'd8};

    pll_dyn_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_ch(req_ch), .req_arg(req_arg), .done(done), .err(err),
        .pll_lock(pll_lock), .pll_reset(pll_reset), .pll_odsel(pll_odsel),
        .pll_pssel(pll_pssel), .pll_psdir(pll_psdir), .pll_pspulse(pll_pspulse),
        .pll_enclk(pll_enclk), .locked(locked), .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest outstanding request
    always @(negedge clk) begin
        exp_t x;
        if (rst_n && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                x = sb.pop_front();
                check({x.name, "_latency"}, cyc - x.acc, x.lat);
                check({x.name, "_err"},     32'(err), 32'(x.err));
                check({x.name, "_odsel"},   32'(pll_odsel), 32'(x.odsel));
                check({x.name, "_enclk"},   32'(pll_enclk), 32'(x.enclk));
                check({x.name, "_locked"},  32'(locked), 32'(x.locked));
            end
        end
    end

    task automatic issue(input string nm, input logic [1:0] op, input logic [2:0] ch,
                         input logic [6:0] arg, input bit push, input int unsigned lat,
                         input logic e, input logic [13:0] od, input logic [1:0] en,
                         input logic lk);
        exp_t x;
        int   n = 0;
        while (req_ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        check({nm, "_ready_wait"}, 32'(req_ready), 32'd1);
        req_op = op; req_ch = ch; req_arg = arg; req_valid = 1'b1;
        if (push) begin
            x.name = nm; x.acc = cyc; x.lat = lat; x.err = e;
            x.odsel = od; x.enclk = en; x.locked = lk;
            sb.push_back(x);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_sb_empty(input string nm, input int unsigned max_cyc);
        int unsigned n = 0;
        while (sb.size() != 0 && n < max_cyc) begin @(negedge clk); n++; end
        check({nm, "_done_wait"}, sb.size(), 32'd0);
    endtask

    task automatic power_up(input bit glitch);
        int n;
        rst_n = 1'b0; pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pll_reset", 32'(pll_reset), 32'd1);
        check("rst_odsel",     32'(pll_odsel), 32'h408);
        check("rst_enclk",     32'(pll_enclk), 32'd0);
        check("rst_outs", {23'd0, locked, req_ready, done, err, pll_pspulse, pll_psdir, pll_pssel},
              32'd0);
        check("rst_loss_cnt",  32'(lock_loss_cnt), 32'd0);
        rst_n = 1'b1;
        n = 0;
        while (pll_reset === 1'b1 && n < 1000) begin n++; @(negedge clk); end
        check("pll_reset_hold", n, 32'd16);
        repeat (100) @(negedge clk);
        pll_lock = 1'b1;
        if (glitch) begin
            repeat (22) @(negedge clk);
            check("locked_before_glitch", 32'(locked), 32'd0);
            pll_lock = 1'b0;
            @(negedge clk);
            pll_lock = 1'b1;
        end
        n = 0;
        while (locked !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check(glitch ? "lock_qual_after_glitch" : "lock_qual_cycles", n, 32'd34);
        check("lock_enclk", 32'(pll_enclk), 32'd3);
        @(negedge clk);
        check("lock_req_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic lock_drop(input int unsigned exp_cnt);
        int n;
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        n = 0;
        while (locked === 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("drop_locked", 32'(locked), 32'd0);
        check("drop_loss_cnt", 32'(lock_loss_cnt), exp_cnt);
`ifdef PLL_AUTO_RELOCK_EN
        n = 0;
        while (pll_reset !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("auto_pll_reset", 32'(pll_reset), 32'd1);
        check("auto_enclk_off", 32'(pll_enclk), 32'd0);
        check("auto_ready_low", 32'(req_ready), 32'd0);
        n = 0;
        while (locked !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check("auto_relocked", 32'(locked), 32'd1);
        check("auto_enclk_on", 32'(pll_enclk), 32'd3);
`else
        repeat (4) @(negedge clk);
        check("idle_locked_low", 32'(locked), 32'd0);
        check("idle_enclk_kept", 32'(pll_enclk), 32'd3);
        check("idle_no_reset",   32'(pll_reset), 32'd0);
        check("idle_ready",      32'(req_ready), 32'd1);
        issue("relock", 2'b10, 3'd0, 7'd0, 1'b1, 49, 1'b0, exp_odsel, 2'b11, 1'b1);
        wait_sb_empty("relock", 100);
`endif
    endtask

    initial begin
        int n;

        // Power-up with a one-cycle lock glitch mid-qualification
        power_up(1'b1);

        // Asynchronous reset in the middle of a divider change
        issue("abort", 2'b00, 3'd0, 7'd3, 1'b0, 0, 1'b0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        check("abort_odsel_written", 32'(pll_odsel[6:0]), 32'd3);
        rst_n = 1'b0;
        #1;
        check("abort_odsel",  32'(pll_odsel), 32'h408);
        check("abort_enclk",  32'(pll_enclk), 32'd0);
        check("abort_reset",  32'(pll_reset), 32'd1);
        check("abort_locked", 32'(locked),    32'd0);

        // Clean power-up
        power_up(1'b0);

        // Set divider: ch1 <= 5
        exp_odsel = {7'd5, 7'd8};
        issue("odiv_ch1", 2'b00, 3'd1, 7'd5, 1'b1, 11, 1'b0, exp_odsel, 2'b11, 1'b1);
        for (int k = 1; k <= 11; k++) begin
            check($sformatf("odiv_enclk1_c%0d", k), 32'(pll_enclk[1]), (k == 11) ? 32'd1 : 32'd0);
            check($sformatf("odiv_enclk0_c%0d", k), 32'(pll_enclk[0]), 32'd1);
            check($sformatf("odiv_ch1_c%0d", k), 32'(pll_odsel[13:7]), (k >= 3) ? 32'd5 : 32'd8);
            check($sformatf("odiv_ch0_c%0d", k), 32'(pll_odsel[6:0]), 32'd8);
            check($sformatf("odiv_ready_c%0d", k), 32'(req_ready), 32'd0);
            if (k < 11) @(negedge clk);
        end
        @(negedge clk);
        check("odiv_ready_after", 32'(req_ready), 32'd1);
        wait_sb_empty("odiv_ch1", 20);

        // Phase step ch0, up, 3 steps
        issue("ps3", 2'b01, 3'd0, 7'b1000011, 1'b1, 16, 1'b0, exp_odsel, 2'b11, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            check($sformatf("ps3_pulse_c%0d", k), 32'(pll_pspulse),
                  (k == 1 || k == 6 || k == 11) ? 32'd1 : 32'd0);
            check($sformatf("ps3_dir_c%0d", k), 32'(pll_psdir), 32'd1);
            check($sformatf("ps3_sel_c%0d", k), 32'(pll_pssel), 32'd0);
            if (k < 16) @(negedge clk);
        end
        @(negedge clk);
        check("ps3_dir_hold", 32'(pll_psdir), 32'd1);
        wait_sb_empty("ps3", 20);

        // Phase step ch1, down, 2 steps
        issue("ps2", 2'b01, 3'd1, 7'b0000010, 1'b1, 11, 1'b0, exp_odsel, 2'b11, 1'b1);
        for (int k = 1; k <= 11; k++) begin
            check($sformatf("ps2_pulse_c%0d", k), 32'(pll_pspulse),
                  (k == 1 || k == 6) ? 32'd1 : 32'd0);
            check($sformatf("ps2_dir_c%0d", k), 32'(pll_psdir), 32'd0);
            check($sformatf("ps2_sel_c%0d", k), 32'(pll_pssel), 32'd1);
            if (k < 11) @(negedge clk);
        end
        wait_sb_empty("ps2", 20);

        // Phase step with zero steps: immediate done, no pulse
        issue("ps0", 2'b01, 3'd0, 7'b1000000, 1'b1, 1, 1'b0, exp_odsel, 2'b11, 1'b1);
        check("ps0_pulse", 32'(pll_pspulse), 32'd0);
        check("ps0_dir",   32'(pll_psdir),   32'd1);
        check("ps0_sel",   32'(pll_pssel),   32'd0);
        wait_sb_empty("ps0", 20);

        // Illegal requests
        issue("bad_ch", 2'b00, 3'd2, 7'd5, 1'b1, 1, 1'b1, exp_odsel, 2'b11, 1'b1);
        check("bad_ch_ready", 32'(req_ready), 32'd0);
        check("bad_ch_pulse", 32'(pll_pspulse), 32'd0);
        wait_sb_empty("bad_ch", 20);
        issue("bad_arg0", 2'b00, 3'd0, 7'd0, 1'b1, 1, 1'b1, exp_odsel, 2'b11, 1'b1);
        wait_sb_empty("bad_arg0", 20);
        issue("bad_op", 2'b11, 3'd1, 7'd9, 1'b1, 1, 1'b1, exp_odsel, 2'b11, 1'b1);
        check("bad_op_sel", 32'(pll_pssel), 32'd0);
        wait_sb_empty("bad_op", 20);

        // Lock loss in IDLE, then saturation of the event counter
        lock_drop(1);
        for (int i = 2; i <= 300; i++) lock_drop((i > 255) ? 255 : i);
        check("loss_cnt_saturated", 32'(lock_loss_cnt), 32'd255);

        // Lock never arrives: timeout error and reset reassertion
        rst_n = 1'b0; pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (pll_reset === 1'b1 && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (err !== 1'b1 && n < 70000) begin @(negedge clk); n++; end
        check("timeout_cycles", n, 32'd65535);
        check("timeout_reset",  32'(pll_reset), 32'd1);
        check("timeout_done",   32'(done), 32'd0);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_dyn_ctrl.md
Name: pll_dyn_ctrl

Overview:
- Sequencer for a GW5A PLL primitive in dynamic mode. Owns the PLL's RESET, per-channel ODSELn, PSSEL/PSDIR/PSPULSE and ENCLKn pins.
- Runs the power-up reset/lock sequence, qualifies lock, counts lock-loss events and executes runtime requests: output-divider change, phase step, full re-lock.
- Sits next to the PLL instance; clocked from the free-running board oscillator, never from a PLL output.

Parameters:
- NUM_CH, 2, PLL output channels controlled (1..7)
- ODIV_INIT, 8, reset value of every channel's divider (1..127)
- RST_CYCLES, 16, cycles pll_reset is held high per reset sequence
- LOCK_STABLE, 32, consecutive synced-lock cycles required before locked=1
- LOCK_TIMEOUT, 65535, WAIT_LOCK cycles before err and retry
- SETTLE_CYCLES, 8, gated cycles after a divider write
- PS_GAP, 4, low cycles between phase-shift pulses

Ports:
- clk  in  1  free-running reference clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request strobe
- req_ready  out  1  high only in IDLE
- req_op  in  2  00=set ODIV, 01=phase step, 10=full re-lock, 11=illegal
- req_ch  in  3  target channel
- req_arg  in  7  ODIV value (op 00); {dir, steps[5:0]} (op 01)
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse
- pll_lock  in  1  raw PLL LOCK, asynchronous
- pll_reset  out  1  to PLL RESET
- pll_odsel  out  7*NUM_CH  channel n divider at [7n+6:7n]
- pll_pssel  out  3  phase-shift channel select
- pll_psdir  out  1  phase-shift direction
- pll_pspulse  out  1  phase-shift step pulse
- pll_enclk  out  NUM_CH  per-channel clock enable
- locked  out  1  qualified lock
- lock_loss_cnt  out  8  saturating lock-loss event count

Behaviour:
- Reset values:
  - pll_reset=1, pll_odsel=ODIV_INIT per channel, pll_enclk=0, locked=0, lock_loss_cnt=0.
  - req_ready, done, err, pll_pspulse, pll_psdir, pll_pssel all 0.
- pll_lock passes a 2-FF synchroniser before any use (2-cycle latency).
- FSM states: RST_ASSERT, WAIT_LOCK, STABLE, IDLE, GATE, WRITE, SETTLE, PS_PULSE, PS_GAP.
- RST_ASSERT: pll_reset=1 for RST_CYCLES cycles, then WAIT_LOCK with pll_reset=0.
- WAIT_LOCK: on synced lock=1 go to STABLE. After LOCK_TIMEOUT cycles: err pulse, back to RST_ASSERT.
- STABLE: counts synced lock=1. Any 0 restarts the count and returns to WAIT_LOCK. Reaching LOCK_STABLE sets locked=1, pll_enclk all 1, and enters IDLE.
- Request acceptance:
  - A request is accepted on the cycle req_valid && req_ready; that is cycle 0. req_ready drops at cycle 1.
  - Illegal request: req_ch>=NUM_CH, op 11, or op 00 with arg 0.
  - Illegal request gives done=1 and err=1 at cycle 1, with no output change.
- Op 00 (set ODIV):
  - pll_enclk[ch]=0 at cycle 1.
  - pll_odsel[ch]=arg at cycle 3.
  - pll_enclk[ch]=1 and done=1 at cycle 3+SETTLE_CYCLES.
  - req_ready=1 from the next cycle.
- Op 01 (phase step):
  - pll_pssel=ch and pll_psdir=arg[6] from cycle 1 until done; they hold their values afterwards.
  - N=arg[5:0] one-cycle pulses; the first at cycle 1, then spaced 1+PS_GAP cycles apart.
  - done one cycle after the final gap completes.
  - N=0: no pulse, done at cycle 1.
- Op 10 (full re-lock): pll_enclk=0 and locked=0 at cycle 1, then RST_ASSERT onward; done pulses on the cycle locked returns to 1.
- Lock loss:
  - Synced lock falling while locked=1, in any state, drops locked on the next cycle.
  - lock_loss_cnt increments once per event, saturating at 255.
  - An in-flight op 00/01 completes normally; lock-loss handling starts on return to IDLE.
- rst_n asserted mid-operation aborts immediately to reset values. Sequencing restarts at RST_ASSERT after release.

Optional Feature:
- Macro PLL_AUTO_RELOCK_EN.
- Defined: on lock loss, the FSM drops pll_enclk to all 0 and enters RST_ASSERT automatically once in IDLE. req_ready stays 0 until re-locked. No done pulse.
- Undefined: the FSM stays in IDLE with locked=0 and pll_enclk unchanged; software must issue op 10.

Test Plan:
- Power-up, pll_lock rises 100 cycles after pll_reset falls, held high -> pll_reset high exactly 16 cycles; locked=1 and pll_enclk=2'b11 at 2+32 cycles after the lock edge; req_ready=1.
- Lock glitch low for 1 cycle at stable count 20 -> count restarts; locked only after 32 further uninterrupted cycles.
- Op 00, ch=1, arg=5 -> pll_enclk[1]=0 cycles 1-10; pll_odsel[13:7]=5 at cycle 3; enclk[1]=1 and done at cycle 11; ch0 untouched.
- Op 01, ch=0, arg=7'b1000011 -> pll_psdir=1, three pulses at cycles 1, 6, 11; done at cycle 16.
- Illegal requests: ch=2 with NUM_CH=2, then op 00 with arg=0 -> done and err at cycle 1, outputs unchanged. pll_lock held 0 -> err after 65535 WAIT_LOCK cycles and pll_reset reasserted.
- Lock drop in IDLE, run twice (macro on and off):
  - On: lock_loss_cnt=1, automatic RST_ASSERT, re-lock.
  - Off: locked=0, FSM stays IDLE, pll_enclk unchanged.
  - 300 drops: counter saturates at 255.
